// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division. Both
// operate on unsigned magnitudes, and the result signs are applied on the
// final iteration. MTHI/MTLO write hi/lo directly in one cycle.
//
// Handshake: start is a request that is sampled only while busy=0, and only
// when cancel=0. An accepted MULT..DIVU raises busy on the accepting edge.
// busy falls on the edge that writes hi/lo. done pulses for the single
// cycle after that edge. A request made while busy=1 is ignored, so the
// requester holds the op until busy=0. cancel aborts a run without writing
// hi/lo and without a done pulse.
module muldiv_unit #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] dInA,
  input  logic [N-1:0] dInB,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t state, state_nxt;
  logic   finish;

  // Operand and iteration state latched when an op is accepted.
  logic [2*N:0]   acc;      // guard bit + 2N working bits
  logic [N-1:0]   opnd;     // |A| for multiply, |B| for divide
  logic [CNT_W-1:0] cnt;
  logic           is_div;
  logic           neg_q;    // negate product / quotient
  logic           neg_r;    // negate remainder

  // Decoded requests (a same-edge cancel suppresses any request).
  logic req_md, req_mthi, req_mtlo;
  logic op_signed, sign_a, sign_b, b_zero;
  logic [N-1:0] mag_a, mag_b;

  assign req_md    = start && !cancel && !op[2];
  assign req_mthi  = start && !cancel && (op == OP_MTHI);
  assign req_mtlo  = start && !cancel && (op == OP_MTLO);
  assign op_signed = !op[0];
  assign sign_a    = op_signed && dInA[N-1];
  assign sign_b    = op_signed && dInB[N-1];
  assign b_zero    = (dInB == '0);
  assign mag_a     = sign_a ? -dInA : dInA;
  assign mag_b     = sign_b ? -dInB : dInB;

  assign busy      = (state == RUN);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave RUN on cancel or when the counter reaches N.
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE: if (req_md) state_nxt = RUN;
      RUN: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(N - 1)) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One multiply step: conditionally add |A| to the upper half, then shift right.
  logic [N:0]   mul_sum;
  logic [2*N:0] mul_next;
  always_comb begin
    mul_sum  = acc[2*N:N] + {1'b0, opnd};
    mul_next = acc[0] ? {1'b0, mul_sum, acc[N-1:1]} : {1'b0, acc[2*N:1]};
  end

  // One restoring-divide step: shift left, trial subtract, keep if non-negative.
  logic [2*N:0] div_shift;
  logic [N:0]   div_trial;
  logic         div_ge;
  logic [2*N:0] div_next;
  always_comb begin
    div_shift = {acc[2*N-1:0], 1'b0};
    div_ge    = (div_shift[2*N:N] >= {1'b0, opnd});
    div_trial = div_shift[2*N:N] - {1'b0, opnd};
    div_next  = div_ge ? {div_trial, div_shift[N-1:1], 1'b1}
                       : {div_shift[2*N:1], 1'b0};
  end

  // Final-step result with sign fixup applied.
  logic [2*N:0]   iter_next;
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   quot, rem, res_hi, res_lo;
  logic           unused_guard;
  always_comb begin
    iter_next    = is_div ? div_next : mul_next;
    unused_guard = iter_next[2*N];
    prod         = iter_next[2*N-1:0];
    prod_fix     = neg_q ? -prod : prod;
    quot         = neg_q ? -iter_next[N-1:0] : iter_next[N-1:0];
    rem          = neg_r ? -iter_next[2*N-1:N] : iter_next[2*N-1:N];
    res_hi       = is_div ? rem  : prod_fix[2*N-1:N];
    res_lo       = is_div ? quot : prod_fix[N-1:0];
  end

  // Datapath: op acceptance, MTHI/MTLO writes, iteration, and result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (state == IDLE) begin
        if (req_md) begin
          is_div <= op[1];
          cnt    <= '0;
          if (op[1]) begin
            acc   <= {1'b0, {N{1'b0}}, mag_a};
            opnd  <= mag_b;
            // A zero divisor leaves the quotient as all-ones. The remainder
            // fixup already restores the raw dividend.
            neg_q <= (sign_a ^ sign_b) && !b_zero;
            neg_r <= sign_a;
          end else begin
            acc   <= {1'b0, {N{1'b0}}, mag_b};
            opnd  <= mag_a;
            neg_q <= sign_a ^ sign_b;
            neg_r <= 1'b0;
          end
        end else if (req_mthi) begin
          hi <= dInA;
        end else if (req_mtlo) begin
          lo <= dInA;
        end
      end else if (!cancel) begin
        acc <= iter_next;
        cnt <= cnt + CNT_W'(1);
        if (finish) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of mult/div vectors, followed by
// hand-written sequences for MTHI/MTLO, cancel, re-pulsed start and reset.
module tb_muldiv_unit;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] din_a;
  logic [N-1:0] din_b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         dbg_state;

  muldiv_unit #(.N(N), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dInA(din_a), .dInB(din_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  // Drives one mult/div op. Checks busy, latency, the done pulse and hi/lo.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cycles;
    @(negedge clk);
    start = 1'b1; op = o; din_a = a; din_b = b;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    cycles = 1;
    while (busy && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_latency"}, 64'(cycles), 64'(N + 1));
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({name, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int ndone;
    int cycles;

    vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{3'b011, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[5]  = '{3'b001, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[8]  = '{3'b000, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'h00000014};
    vecs[9]  = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{3'b000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[12] = '{3'b011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

    rst = 1'b1; start = 1'b0; op = 3'b000; din_a = '0; din_b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);

    // MTLO while idle: lo updates on the accepting edge, no busy.
    start = 1'b1; op = 3'b101; din_a = 32'hCAFEBABE;
    @(negedge clk);
    check("mtlo_lo", 64'(lo), 64'hCAFEBABE);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    // MTHI, then MULT 5x5 cancelled at cycle 10.
    op = 3'b100; din_a = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h12345678);
    op = 3'b000; din_a = 32'd5; din_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("cancel_busy_run", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hi", 64'(hi), 64'h12345678);
    check("cancel_lo", 64'(lo), 64'hCAFEBABE);
    check("cancel_done", 64'(done), 64'd0);
    @(negedge clk);
    check("cancel_done_late", 64'(done), 64'd0);

    // Table-driven mult/div vectors.
    for (int i = 0; i < 13; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo);

    // DIVU 100/0 with start re-pulsed while busy: a single done.
    @(negedge clk);
    start = 1'b1; op = 3'b011; din_a = 32'd100; din_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b000; din_a = 32'd5; din_b = 32'd5;
    repeat (3) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("repulse_ndone", 64'(ndone), 64'd1);
    check("repulse_hi", 64'(hi), 64'h64);
    check("repulse_lo", 64'(lo), 64'hFFFFFFFF);

    // Cancel on the same edge as the final iteration: cancel wins.
    start = 1'b1; op = 3'b001; din_a = 32'd3; din_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (N - 1) @(negedge clk);
    check("lastcancel_busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("lastcancel_busy", 64'(busy), 64'd0);
    check("lastcancel_done", 64'(done), 64'd0);
    check("lastcancel_hi", 64'(hi), 64'h64);
    check("lastcancel_lo", 64'(lo), 64'hFFFFFFFF);
    @(negedge clk);
    check("lastcancel_done_late", 64'(done), 64'd0);

    // Cancel in IDLE suppresses a same-edge start (MTHI and MULT).
    start = 1'b1; cancel = 1'b1; op = 3'b100; din_a = 32'hDEADBEEF;
    @(negedge clk);
    check("idlecancel_mthi_hi", 64'(hi), 64'h64);
    op = 3'b000; din_a = 32'd2; din_b = 32'd2;
    @(negedge clk);
    check("idlecancel_mult_busy", 64'(busy), 64'd0);
    start = 1'b0; cancel = 1'b0;

    // op 11x does nothing.
    start = 1'b1; op = 3'b111; din_a = 32'd1; din_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_hi", 64'(hi), 64'h64);
    check("nop_lo", 64'(lo), 64'hFFFFFFFF);

    // Asynchronous reset mid-run.
    start = 1'b1; op = 3'b000; din_a = 32'd5; din_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) cycles++;
    end
    check("rst_quiet", 64'(cycles), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
